// File: rtl/x4xx_versioning_scanner_pkg.sv
// ============================================================================
// Module      : x4xx_versioning_scanner_pkg
// Description : Shared constants, state encoding and address helper for the
//               versioning register scanner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package x4xx_versioning_scanner_pkg;

    localparam int MAX_NUM_OF_COMPONENTS = 64;
    localparam int IDX_W                 = 6;

    // {MAJOR, MINOR, BUILD} layout of a version word
    localparam int VERSION_MAJOR_MSB = 31;
    localparam int VERSION_MAJOR_LSB = 23;
    localparam int VERSION_MINOR_MSB = 22;
    localparam int VERSION_MINOR_LSB = 12;
    localparam int VERSION_BUILD_MSB = 11;
    localparam int VERSION_BUILD_LSB = 0;

    localparam int CTRL_ADDR_W = 20;
    localparam int CTRL_DATA_W = 32;

    localparam logic [CTRL_ADDR_W-1:0] CURRENT_VERSION_OFFSET   = 20'h0;
    localparam logic [CTRL_ADDR_W-1:0] OLDEST_COMPATIBLE_OFFSET = 20'h4;
    localparam int                     COMPONENT_STEP           = 16;
    localparam int                     COMPONENT_STEP_LOG2      = 4;

    localparam logic [1:0] CTRL_STS_OKAY    = 2'd0;
    localparam logic [1:0] CTRL_STS_CMDERR  = 2'd1;
    localparam logic [1:0] CTRL_STS_TSERR   = 2'd2;
    localparam logic [1:0] CTRL_STS_WARNING = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SELECT   = 4'd1,
        ST_REQ_CUR  = 4'd2,
        ST_WAIT_CUR = 4'd3,
        ST_REQ_OLD  = 4'd4,
        ST_WAIT_OLD = 4'd5,
        ST_CHECK    = 4'd6,
        ST_NEXT     = 4'd7,
        ST_DONE     = 4'd8
    } scan_state_t;

    function automatic logic [CTRL_ADDR_W-1:0] component_addr(
        input logic [CTRL_ADDR_W-1:0] base,
        input logic [IDX_W-1:0]       idx,
        input logic [CTRL_ADDR_W-1:0] offset
    );
        return base + ({{(CTRL_ADDR_W-IDX_W){1'b0}}, idx} << COMPONENT_STEP_LOG2) + offset;
    endfunction

endpackage

`default_nettype wire

// File: rtl/x4xx_versioning_scanner_if.sv
// ============================================================================
// Module      : x4xx_versioning_scanner_if
// Description : Ctrlport request/response bundle used by the scanner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface x4xx_versioning_scanner_if;
    import x4xx_versioning_scanner_pkg::*;

    logic                   req_wr;
    logic                   req_rd;
    logic [CTRL_ADDR_W-1:0] req_addr;
    logic [CTRL_DATA_W-1:0] req_data;
    logic                   resp_ack;
    logic [1:0]             resp_status;
    logic [CTRL_DATA_W-1:0] resp_data;

    modport master (
        output req_wr, req_rd, req_addr, req_data,
        input  resp_ack, resp_status, resp_data
    );

    modport slave (
        input  req_wr, req_rd, req_addr, req_data,
        output resp_ack, resp_status, resp_data
    );
endinterface

`default_nettype wire

// File: rtl/x4xx_version_compare.sv
// ============================================================================
// Module      : x4xx_version_compare
// Description : Unsigned whole-word comparison of hardware vs software versions.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module x4xx_version_compare (
    input  wire logic [31:0] cur,
    input  wire logic [31:0] old,
    input  wire logic [31:0] sw_cur,
    input  wire logic [31:0] sw_old,
    output logic             too_old,
    output logic             too_new
);
    assign too_old = (sw_old > cur);
    assign too_new = (sw_cur < old);
endmodule

`default_nettype wire

// File: rtl/x4xx_versioning_scanner.sv
// ============================================================================
// Module      : x4xx_versioning_scanner
// Description : Ctrlport master that reads every enabled component's version
//               registers and flags incompatibilities with software.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module x4xx_versioning_scanner
    import x4xx_versioning_scanner_pkg::*;
#(
    parameter logic [CTRL_ADDR_W-1:0] REG_BASE       = 20'h0,
    parameter int                     NUM_COMPONENTS = 64,
    parameter int                     TIMEOUT        = 255
) (
    input  wire logic                         ctrlport_clk,
    input  wire logic                         ctrlport_rst_n,
    input  wire logic                         start,
    input  wire logic [NUM_COMPONENTS-1:0]    comp_enable,
    input  wire logic [NUM_COMPONENTS*32-1:0] sw_current_version,
    input  wire logic [NUM_COMPONENTS*32-1:0] sw_oldest_compat,
    output logic                              busy,
    output logic                              done,
    output logic                              compat_ok,
    output logic [NUM_COMPONENTS-1:0]         too_old_mask,
    output logic [NUM_COMPONENTS-1:0]         too_new_mask,
    output logic [NUM_COMPONENTS-1:0]         error_mask,
    x4xx_versioning_scanner_if.master         m_ctrlport
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    scan_state_t                      r_state;
    scan_state_t                      w_state_next;
    logic [IDX_W-1:0]                 r_idx;
    logic [CNT_W-1:0]                 r_cnt;
    logic [31:0]                      r_cur;
    logic [31:0]                      r_old;
    logic [MAX_NUM_OF_COMPONENTS-1:0] r_too_old;
    logic [MAX_NUM_OF_COMPONENTS-1:0] r_too_new;
    logic [MAX_NUM_OF_COMPONENTS-1:0] r_error;
    logic                             r_compat_ok;

    // Widen per-component inputs to the full 6-bit index space so idx never selects out of range
    logic [MAX_NUM_OF_COMPONENTS-1:0] w_enable;
    logic [31:0]                      w_sw_cur_arr [MAX_NUM_OF_COMPONENTS];
    logic [31:0]                      w_sw_old_arr [MAX_NUM_OF_COMPONENTS];

    assign w_enable = MAX_NUM_OF_COMPONENTS'(comp_enable);

    for (genvar i = 0; i < MAX_NUM_OF_COMPONENTS; i++) begin : g_sw_unpack
        if (i < NUM_COMPONENTS) begin : g_used
            assign w_sw_cur_arr[i] = sw_current_version[i*32 +: 32];
            assign w_sw_old_arr[i] = sw_oldest_compat[i*32 +: 32];
        end else begin : g_pad
            assign w_sw_cur_arr[i] = 32'd0;
            assign w_sw_old_arr[i] = 32'd0;
        end
    end

    logic w_too_old;
    logic w_too_new;

    x4xx_version_compare u_compare (
        .cur     (r_cur),
        .old     (r_old),
        .sw_cur  (w_sw_cur_arr[r_idx]),
        .sw_old  (w_sw_old_arr[r_idx]),
        .too_old (w_too_old),
        .too_new (w_too_new)
    );

    logic w_okay;
    logic w_timeout;
    logic w_last;

    assign w_okay    = (m_ctrlport.resp_status == CTRL_STS_OKAY);
    // Counter holds the number of WAIT cycles already spent, so this is the TIMEOUT-th one
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_last    = (r_idx == IDX_W'(NUM_COMPONENTS - 1));

    always_ff @(posedge ctrlport_clk) begin
        if (!ctrlport_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        busy                = (r_state != ST_IDLE);
        done                = (r_state == ST_DONE);
        m_ctrlport.req_rd   = 1'b0;
        m_ctrlport.req_addr = '0;
        case (r_state)
            ST_IDLE:    if (start) w_state_next = ST_SELECT;
            ST_SELECT:  w_state_next = w_enable[r_idx] ? ST_REQ_CUR : ST_NEXT;
            ST_REQ_CUR: begin
                m_ctrlport.req_rd   = 1'b1;
                m_ctrlport.req_addr = component_addr(REG_BASE, r_idx, CURRENT_VERSION_OFFSET);
                w_state_next        = ST_WAIT_CUR;
            end
            ST_WAIT_CUR: begin
                if (m_ctrlport.resp_ack) begin
                    // A zero current version marks an absent component
                    w_state_next = (!w_okay || m_ctrlport.resp_data == 32'd0) ? ST_NEXT : ST_REQ_OLD;
                end else if (w_timeout) begin
                    w_state_next = ST_NEXT;
                end
            end
            ST_REQ_OLD: begin
                m_ctrlport.req_rd   = 1'b1;
                m_ctrlport.req_addr = component_addr(REG_BASE, r_idx, OLDEST_COMPATIBLE_OFFSET);
                w_state_next        = ST_WAIT_OLD;
            end
            ST_WAIT_OLD: begin
                if (m_ctrlport.resp_ack) begin
                    w_state_next = w_okay ? ST_CHECK : ST_NEXT;
                end else if (w_timeout) begin
                    w_state_next = ST_NEXT;
                end
            end
            ST_CHECK:   w_state_next = ST_NEXT;
            ST_NEXT:    w_state_next = w_last ? ST_DONE : ST_SELECT;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ctrlport_clk) begin
        if (!ctrlport_rst_n) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_cur       <= '0;
            r_old       <= '0;
            r_too_old   <= '0;
            r_too_new   <= '0;
            r_error     <= '0;
            r_compat_ok <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_too_old   <= '0;
                        r_too_new   <= '0;
                        r_error     <= '0;
                        r_compat_ok <= 1'b0;
                    end
                end
                ST_REQ_CUR, ST_REQ_OLD: r_cnt <= '0;
                ST_WAIT_CUR, ST_WAIT_OLD: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (m_ctrlport.resp_ack) begin
                        if (!w_okay) begin
                            r_error[r_idx] <= 1'b1;
                        end else if (r_state == ST_WAIT_CUR) begin
                            r_cur <= m_ctrlport.resp_data;
                        end else begin
                            r_old <= m_ctrlport.resp_data;
                        end
                    end else if (w_timeout) begin
                        r_error[r_idx] <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_too_old[r_idx] <= w_too_old;
                    r_too_new[r_idx] <= w_too_new;
                end
                ST_NEXT: begin
                    if (w_last) begin
                        r_compat_ok <= ~|(r_too_old | r_too_new | r_error);
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_ctrlport.req_wr   = 1'b0;
    assign m_ctrlport.req_data = '0;
    assign compat_ok           = r_compat_ok;
    assign too_old_mask        = r_too_old[NUM_COMPONENTS-1:0];
    assign too_new_mask        = r_too_new[NUM_COMPONENTS-1:0];
    assign error_mask          = r_error[NUM_COMPONENTS-1:0];

endmodule

`default_nettype wire
